spdif_frame_sequencer: RTL

Splits stereo sample pairs into ordered left/right sub-frame requests for `spdif_sub_frame_encoder`, sitting directly upstream of it. Tracks the 192-frame channel-status block, flags block start on frame 0, and serialises a 40-bit consumer channel-status word onto the C bit. The user bit is driven 0.

---
 rtl/spdif_pkg.sv | 14 +
 rtl/spdif_frame_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/spdif_pkg.sv
// Shared S/PDIF definitions: block geometry, channel-status width and
// the frame sequencer state encoding.
package spdif_pkg;

   localparam int unsigned FRAMES_PER_BLOCK  = 192;
   localparam int unsigned CS_CONSUMER_WIDTH = 40;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_LEFT  = 2'd1,
      SEQ_RIGHT = 2'd2
   } seq_state_t;

endpackage

// File: rtl/spdif_frame_sequencer.sv
// Splits stereo pairs into left/right sub-frame requests, tracks the
// 192-frame block position and serialises channel status onto o_control.
module spdif_frame_sequencer
   import spdif_pkg::*;
#(
   parameter int unsigned audio_width = 24,
   parameter int unsigned cs_width    = CS_CONSUMER_WIDTH
) (
   input  logic                   clk128,
   input  logic                   reset,
   input  logic                   i_valid,
   output logic                   i_ready,
   input  logic [audio_width-1:0] i_left,
   input  logic [audio_width-1:0] i_right,
   input  logic [cs_width-1:0]    i_cs,
   input  logic                   i_resync,
   output logic                   o_valid,
   input  logic                   o_ready,
   output logic                   o_is_frame_start,
   output logic                   o_is_left,
   output logic [audio_width-1:0] o_audio,
   output logic                   o_user,
   output logic                   o_control,
   output logic [7:0]             o_frame_index
);

   localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_BLOCK - 1);

   seq_state_t                  state, state_d;
   logic [audio_width-1:0]      right_q, right_d;
   logic [cs_width-1:0]         cs_q, cs_d;
   logic [7:0]                  index_q, index_d, accept_index;
   logic                        resync_q, resync_d;
   logic                        valid_d, is_left_d, start_d, control_d;
   logic [audio_width-1:0]      audio_d;
   logic [FRAMES_PER_BLOCK-1:0] cs_ext;

   assign i_ready       = (state == SEQ_IDLE);
   assign o_user        = 1'b0;
   assign o_frame_index = index_q;

   always_ff @(posedge clk128 or posedge reset) begin
      if (reset) state <= SEQ_IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d      = state;
      right_d      = right_q;
      cs_d         = cs_q;
      index_d      = index_q;
      resync_d     = resync_q | i_resync;
      valid_d      = o_valid;
      is_left_d    = o_is_left;
      start_d      = o_is_frame_start;
      audio_d      = o_audio;
      control_d    = o_control;
      accept_index = index_q;
      cs_ext       = FRAMES_PER_BLOCK'(cs_q);
      case (state)
         SEQ_IDLE: begin
            if (i_valid) begin
               // A pending or same-cycle resync forces this pair to frame 0
               accept_index = (resync_q | i_resync) ? '0 : index_q;
               index_d      = accept_index;
               resync_d     = 1'b0;
               right_d      = i_right;
               if (accept_index == '0) cs_d = i_cs;
               cs_ext       = FRAMES_PER_BLOCK'(cs_d);
               valid_d      = 1'b1;
               is_left_d    = 1'b1;
               start_d      = (accept_index == '0);
               audio_d      = i_left;
               control_d    = cs_ext[accept_index];
               state_d      = SEQ_LEFT;
            end
         end
         SEQ_LEFT: begin
            if (o_ready) begin
               is_left_d = 1'b0;
               start_d   = 1'b0;
               audio_d   = right_q;
               state_d   = SEQ_RIGHT;
            end
         end
         SEQ_RIGHT: begin
            if (o_ready) begin
               valid_d = 1'b0;
               index_d = (index_q == LAST_FRAME) ? '0 : index_q + 8'd1;
               state_d = SEQ_IDLE;
            end
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   always_ff @(posedge clk128 or posedge reset) begin
      if (reset) begin
         right_q          <= '0;
         cs_q             <= '0;
         index_q          <= '0;
         resync_q         <= 1'b0;
         o_valid          <= 1'b0;
         o_is_left        <= 1'b0;
         o_is_frame_start <= 1'b0;
         o_audio          <= '0;
         o_control        <= 1'b0;
      end else begin
         right_q          <= right_d;
         cs_q             <= cs_d;
         index_q          <= index_d;
         resync_q         <= resync_d;
         o_valid          <= valid_d;
         o_is_left        <= is_left_d;
         o_is_frame_start <= start_d;
         o_audio          <= audio_d;
         o_control        <= control_d;
      end
   end

endmodule
